aq_djpeg_feeder: RTL and testbench
==================================

Name: aq_djpeg_feeder

Overview:
- Memory-to-decoder input sequencer for aq_djpeg.
- Fetches a JPEG bitstream of WordCount 32-bit words from a word-addressed memory read port, starting at BaseAddr, and buffers the words in a small show-ahead FIFO.
- Drives the decoder's DataIn/DataInEnable/DataInRead handshake and detects end-of-decode from JpegDecodeIdle.
- Sits between the system memory/bus and aq_djpeg and replaces the bench-style direct memory feed.

Parameters:
- ADDR_W, 32, memory word-address width.
- FIFO_DEPTH, 8, input FIFO entries; power of 2, at least 2.
- MAX_OUTSTANDING, 4, maximum granted-but-unreturned reads; must be ≤ FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle job start; ignored unless Busy=0.
- Abort  in  1  terminate the current job.
- BaseAddr  in  ADDR_W  first word address, sampled on accepted Start.
- WordCount  in  20  words in the job, sampled on accepted Start.
- Busy  out  1  job in progress.
- Done  out  1  one-cycle pulse at job end.
- Underrun  out  1  sticky per job: all words consumed while the decoder was still busy.
- ConsumedCount  out  20  words accepted by the decoder in the current or last job.
- MemReq  out  1  read request.
- MemAddr  out  ADDR_W  read address.
- MemGnt  in  1  request accepted this cycle.
- MemRdValid  in  1  read data valid; data returns in request order.
- MemRdData  in  32  read data.
- DataIn  out  32  FIFO head word, to the decoder.
- DataInEnable  out  1  DataIn is valid.
- DataInRead  in  1  decoder consumes DataIn on an edge where DataInEnable=1.
- JpegDecodeIdle  in  1  decoder idle.

Behaviour:
- Reset (rst=0 at a clk edge) gives:
  - State IDLE; FIFO, outstanding count and issue count cleared.
  - Busy=0, Done=0, Underrun=0, ConsumedCount=0, MemReq=0, MemAddr=0, DataInEnable=0, DataIn=0.
  - Reset mid-job aborts with no Done pulse.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - Start=1 latches BaseAddr/WordCount and clears ConsumedCount, Underrun and SeenBusy.
  - WordCount=0: go to DONE. Otherwise go to RUN.
  - Busy=1 from the cycle after Start.
  - MemRdValid is ignored in IDLE.
- RUN, request issue:
  - MemReq=1 when issued<WordCount, outstanding<MAX_OUTSTANDING and fifo_count+outstanding<FIFO_DEPTH.
  - MemAddr=BaseAddr+issued, modulo 2^ADDR_W.
  - MemReq/MemAddr are registered and held stable until MemGnt.
  - On MemReq&&MemGnt: issued+1, outstanding+1. On MemRdValid: outstanding−1. Both in the same cycle leave outstanding unchanged.
  - The first MemReq appears in the cycle after Start.
- RUN, FIFO and decoder handshake:
  - MemRdValid pushes MemRdData into the FIFO. It never overflows because of the credit rule.
  - DataInEnable = (state==RUN) && fifo_count≠0. DataIn = FIFO head (show-ahead, combinational from registered storage).
  - A word pushed at edge n is visible on DataIn/DataInEnable in cycle n+1.
  - Pop on DataInEnable&&DataInRead; ConsumedCount+1. Push and pop in the same cycle are legal; the count is unchanged.
  - DataIn is held stable while DataInEnable=1 and DataInRead=0.
- Completion:
  - SeenBusy is set on any RUN cycle with JpegDecodeIdle=0.
  - In RUN, SeenBusy=1 with JpegDecodeIdle=1 goes to FLUSH. Trailing unconsumed words are legal (padding after EOI).
  - In RUN, ConsumedCount==WordCount with SeenBusy=1 and JpegDecodeIdle=0 sets Underrun=1 and stays in RUN until the decoder goes idle.
  - Abort=1 in RUN goes to FLUSH.
- FLUSH:
  - MemReq=0; an already-registered MemReq is withdrawn. DataInEnable=0.
  - Returning data is discarded; the FIFO is cleared.
  - Go to DONE when outstanding==0.
- DONE: Done=1 for exactly one cycle, Busy=0 in the following cycle, then IDLE. Underrun and ConsumedCount hold until the next Start.
- Start/Abort during DONE or FLUSH are ignored. Abort in IDLE is ignored.

Test Plan:
1. Start, BaseAddr=0x100, WordCount=6, memory latency 3, decoder DataInRead always 1, JpegDecodeIdle low after the first word and high after the 6th is consumed -> MemAddr sequence 0x100..0x105, DataIn equals memory words in order, Done one pulse, ConsumedCount=6, Underrun=0.
2. DataInRead held 0 for 20 cycles with MemGnt always 1 -> at most FIFO_DEPTH=8 words issued, MemReq deasserts, DataIn stable; release -> remaining words delivered in order without loss or duplication.
3. WordCount=4, decoder stays busy after consuming all 4 -> Underrun=1, no Done until JpegDecodeIdle=1, then Done.
4. WordCount=16, decoder goes idle after 10 words with 3 reads outstanding -> FLUSH discards the 3 returns, Done only after outstanding reaches 0, ConsumedCount=10.
5. Abort mid-job, then Start again with BaseAddr=0x200 -> second job starts at 0x200 with an empty FIFO; Start asserted during the first job is ignored.
6. rst=0 mid-job for 1 cycle -> all outputs return to reset values the next cycle; no Done pulse; a later Start works normally.

Source files
------------

// File: rtl/aq_djpeg_feeder.sv
// Memory-to-decoder input sequencer for aq_djpeg: fetches a word stream into a
// show-ahead FIFO and drives the decoder's DataIn handshake until end-of-decode.
module aq_djpeg_feeder #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [19:0]       WordCount,
    output logic              Busy,
    output logic              Done,
    output logic              Underrun,
    output logic [19:0]       ConsumedCount,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemGnt,
    input  logic              MemRdValid,
    input  logic [31:0]       MemRdData,
    output logic [31:0]       DataIn,
    output logic              DataInEnable,
    input  logic              DataInRead,
    input  logic              JpegDecodeIdle
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] MaxOut   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DepthLim = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [19:0]       wc_q, wc_d;
    logic [19:0]       issued_q, issued_d;
    logic [19:0]       consumed_q, consumed_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic              underrun_q, underrun_d;
    logic              seen_busy_q, seen_busy_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              start_acc;
    logic              in_run;
    logic              in_flush;
    logic              grant;
    logic              ret;
    logic              push;
    logic              pop;
    logic              can_issue;
    logic [CNT_W:0]    credit_used;

    assign in_run    = (state_q == StRun);
    assign in_flush  = (state_q == StFlush);
    assign start_acc = (state_q == StIdle) && Start;
    assign grant     = mem_req_q && MemGnt;
    // Returns only count while reads are in flight; in FLUSH they are dropped.
    assign ret       = MemRdValid && (in_run || in_flush) && (outst_q != '0);
    assign push      = ret && in_run;
    assign pop       = DataInEnable && DataInRead;

    assign Busy          = (state_q != StIdle);
    assign Done          = (state_q == StDone);
    assign Underrun      = underrun_q;
    assign ConsumedCount = consumed_q;
    assign MemReq        = mem_req_q;
    assign MemAddr       = mem_addr_q;
    assign DataInEnable  = in_run && (fifo_cnt_q != '0);
    assign DataIn        = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = (WordCount == 20'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (Abort || (seen_busy_q && JpegDecodeIdle)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (outst_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base_d      = base_q;
        wc_d        = wc_q;
        issued_d    = issued_q;
        consumed_d  = consumed_q;
        underrun_d  = underrun_q;
        seen_busy_d = seen_busy_q;
        if (start_acc) begin
            base_d      = BaseAddr;
            wc_d        = WordCount;
            issued_d    = '0;
            consumed_d  = '0;
            underrun_d  = 1'b0;
            seen_busy_d = 1'b0;
        end else begin
            if (grant) begin
                issued_d = issued_q + 20'd1;
            end
            if (pop) begin
                consumed_d = consumed_q + 20'd1;
            end
            if (in_run && !JpegDecodeIdle) begin
                seen_busy_d = 1'b1;
                // Decoder still wants data but every word has been handed over.
                if (seen_busy_q && (consumed_q == wc_q)) begin
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (grant && !ret) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!grant && ret) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    always_comb begin
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        fifo_cnt_d = '0;
        if (in_run) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // Credits are judged on next-cycle occupancy so a granted read always has a slot.
    always_comb begin
        credit_used = {1'b0, fifo_cnt_d} + {1'b0, outst_d};
        can_issue   = (state_d == StRun) && (issued_d < wc_d) && (outst_d < MaxOut) &&
                      (credit_used < DepthLim);
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        if (state_d == StRun) begin
            if (mem_req_q && !MemGnt) begin
                mem_req_d = 1'b1;
            end else if (can_issue) begin
                mem_req_d  = 1'b1;
                mem_addr_d = base_d + ADDR_W'(issued_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            wc_q        <= '0;
            issued_q    <= '0;
            consumed_q  <= '0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underrun_q  <= 1'b0;
            seen_busy_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wc_q        <= wc_d;
            issued_q    <= issued_d;
            consumed_q  <= consumed_d;
            outst_q     <= outst_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            underrun_q  <= underrun_d;
            seen_busy_q <= seen_busy_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr_q] <= MemRdData;
        end
    end

endmodule

// File: tb/tb_aq_djpeg_feeder.sv
// Self-checking bench for aq_djpeg_feeder: memory and decoder models plus an
// every-cycle checker of address order, data order, credit limits and handshakes.
module tb_aq_djpeg_feeder;

    localparam int FIFO_DEPTH = 8;
    localparam int MAX_OUT    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic        Abort;
    logic [31:0] BaseAddr;
    logic [19:0] WordCount;
    logic        Busy;
    logic        Done;
    logic        Underrun;
    logic [19:0] ConsumedCount;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemGnt         = 1'b0;
    logic        MemRdValid     = 1'b0;
    logic [31:0] MemRdData      = 32'h0;
    logic [31:0] DataIn;
    logic        DataInEnable;
    logic        DataInRead     = 1'b0;
    logic        JpegDecodeIdle = 1'b1;

    always #5 clk = ~clk;

    aq_djpeg_feeder #(
        .ADDR_W         (32),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Start         (Start),
        .Abort         (Abort),
        .BaseAddr      (BaseAddr),
        .WordCount     (WordCount),
        .Busy          (Busy),
        .Done          (Done),
        .Underrun      (Underrun),
        .ConsumedCount (ConsumedCount),
        .MemReq        (MemReq),
        .MemAddr       (MemAddr),
        .MemGnt        (MemGnt),
        .MemRdValid    (MemRdValid),
        .MemRdData     (MemRdData),
        .DataIn        (DataIn),
        .DataInEnable  (DataInEnable),
        .DataInRead    (DataInRead),
        .JpegDecodeIdle(JpegDecodeIdle)
    );

    int tests = 0;
    int fails = 0;

    // Knobs set by the stimulus process.
    int read_en    = 1;
    int gnt_pat    = 0;
    int lat        = 3;
    int idle_after = 1000;

    // Model state owned by the checker process.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;
    rd_t         pend[$];
    rd_t         ent;
    logic [31:0] base_m     = 32'h0;
    int          wc_m       = 0;
    int          issued_m   = 0;
    int          consumed_m = 0;
    int          done_cnt   = 0;
    int          cyc        = 0;
    logic [31:0] first_data = 32'h0;
    logic [31:0] last_addr  = 32'h0;
    bit          dec_done;
    bit          prev_req   = 1'b0;
    bit          prev_gnt   = 1'b0;
    bit          prev_en    = 1'b0;
    bit          prev_rd    = 1'b0;
    bit          prev_done  = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    logic [31:0] prev_data  = 32'h0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs driven 1 after the falling edge, outputs judged 2 after it.
    always @(negedge clk) begin
        #1;
        cyc++;
        dec_done       = (consumed_m >= idle_after);
        MemRdValid     = (pend.size() > 0) && (pend[0].due <= cyc);
        MemRdData      = MemRdValid ? memword(pend[0].addr) : 32'hBAD0BAD0;
        MemGnt         = (gnt_pat == 0) || ((cyc % 3) != 0);
        DataInRead     = (read_en != 0) && !dec_done;
        JpegDecodeIdle = (consumed_m == 0) || dec_done;
        #1;
        if (!rst) begin
            pend.delete();
            consumed_m = 0;
            issued_m   = 0;
            prev_req   = 1'b0;
            prev_gnt   = 1'b0;
            prev_en    = 1'b0;
            prev_rd    = 1'b0;
            prev_done  = 1'b0;
        end else begin
            check("consumed_count", ConsumedCount, consumed_m);
            if (!Busy) begin
                check("idle_no_req", MemReq, 0);
                check("idle_no_data", DataInEnable, 0);
            end
            if (Done) begin
                check("done_single", prev_done, 0);
                check("done_outstanding", pend.size(), 0);
                check("done_busy", Busy, 1);
                done_cnt++;
            end
            if (prev_req && !prev_gnt && MemReq) check("req_hold_addr", MemAddr, prev_addr);
            if (prev_en && !prev_rd && DataInEnable) check("data_hold", DataIn, prev_data);
            if (MemReq && MemGnt) begin
                check("mem_addr", MemAddr, base_m + 32'(issued_m));
                check("issue_limit", issued_m < wc_m, 1);
                check("credit", (issued_m - consumed_m) < FIFO_DEPTH, 1);
                check("outstanding", pend.size() < MAX_OUT, 1);
                ent.addr = MemAddr;
                ent.due  = cyc + lat;
                pend.push_back(ent);
                issued_m++;
                last_addr = MemAddr;
            end
            if (MemRdValid && pend.size() > 0) void'(pend.pop_front());
            if (DataInEnable && DataInRead) begin
                check("consume_order", DataIn, memword(base_m + 32'(consumed_m)));
                check("consume_limit", consumed_m < wc_m, 1);
                if (consumed_m == 0) first_data = DataIn;
                consumed_m++;
            end
            if (Start && !Busy) begin
                base_m     = BaseAddr;
                wc_m       = int'(WordCount);
                issued_m   = 0;
                consumed_m = 0;
            end
            prev_req  = MemReq;
            prev_gnt  = MemGnt;
            prev_addr = MemAddr;
            prev_en   = DataInEnable;
            prev_rd   = DataInRead;
            prev_data = DataIn;
            prev_done = Done;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_underrun"}, Underrun, 0);
        check({tag, "_consumed"}, ConsumedCount, 0);
        check({tag, "_memreq"}, MemReq, 0);
        check({tag, "_memaddr"}, MemAddr, 0);
        check({tag, "_datainen"}, DataInEnable, 0);
        check({tag, "_datain"}, DataIn, 0);
    endtask

    task automatic start_job(input logic [31:0] base, input int wc, input int idle_at);
        @(negedge clk);
        idle_after = idle_at;
        BaseAddr   = base;
        WordCount  = 20'(wc);
        Start      = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached"}, done_cnt - d0, 1);
        check({name, "_busy_low"}, Busy, 0);
    endtask

    initial begin
        int d0;
        int n;
        rst       = 1'b0;
        Start     = 1'b0;
        Abort     = 1'b0;
        BaseAddr  = 32'h0;
        WordCount = 20'h0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        // 1: basic job with a stuttering grant
        gnt_pat = 1;
        start_job(32'h100, 6, 6);
        wait_done(300, "t1");
        check("t1_consumed", ConsumedCount, 6);
        check("t1_underrun", Underrun, 0);
        check("t1_issued", issued_m, 6);
        check("t1_last_addr", last_addr, 32'h105);
        check("t1_first_data", first_data, 32'hC0DE0100);
        check("t1_done_count", done_cnt, 1);

        // 2: decoder stalled, credit cap
        gnt_pat = 0;
        read_en = 0;
        start_job(32'h140, 12, 12);
        repeat (20) @(negedge clk);
        check("t2_issued_cap", issued_m, 8);
        check("t2_memreq_low", MemReq, 0);
        check("t2_busy", Busy, 1);
        check("t2_head_valid", DataInEnable, 1);
        check("t2_head_data", DataIn, 32'hC0DE0140);
        read_en = 1;
        wait_done(300, "t2");
        check("t2_consumed", ConsumedCount, 12);
        check("t2_issued", issued_m, 12);

        // 3: underrun
        start_job(32'h180, 4, 1000);
        n = 0;
        while (consumed_m < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t3_consumed_reached", consumed_m, 4);
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        check("t3_underrun", Underrun, 1);
        check("t3_still_busy", Busy, 1);
        check("t3_no_done", done_cnt, d0);
        idle_after = 0;
        wait_done(100, "t3");
        check("t3_underrun_hold", Underrun, 1);
        check("t3_consumed", ConsumedCount, 4);

        // 4: early end with reads in flight
        start_job(32'h1C0, 16, 10);
        wait_done(300, "t4");
        check("t4_consumed", ConsumedCount, 10);
        check("t4_issued_beyond", issued_m > 10, 1);
        check("t4_pend_empty", pend.size(), 0);
        check("t4_underrun", Underrun, 0);

        // 5: abort, ignored Start mid-job, Abort in idle, restart
        start_job(32'h300, 16, 1000);
        repeat (3) @(negedge clk);
        BaseAddr  = 32'h400;
        WordCount = 20'd2;
        Start     = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        wait_done(200, "t5a");
        check("t5_ignored_start", last_addr & 32'hFFFFFF00, 32'h300);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        @(negedge clk);
        check("t5_idle_abort", Busy, 0);
        start_job(32'h200, 5, 5);
        wait_done(300, "t5b");
        check("t5_first_data", first_data, 32'hC0DE0200);
        check("t5_consumed", ConsumedCount, 5);
        check("t5_last_addr", last_addr, 32'h204);

        // 6: reset mid-job
        start_job(32'h500, 16, 1000);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset("t6");
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt, d0);
        check("t6_idle", Busy, 0);
        start_job(32'h600, 3, 3);
        wait_done(200, "t6");
        check("t6_consumed", ConsumedCount, 3);
        check("t6_first_data", first_data, 32'hC0DE0600);

        // Zero-length job
        start_job(32'h700, 0, 0);
        wait_done(20, "t7");
        check("t7_issued", issued_m, 0);
        check("t7_consumed", ConsumedCount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
